// File: rtl/frequency_analysis_sequencer_pkg.sv
// Shared definitions for the frequency analysis sequencer: register-port
// operation codes, the run state encoding and a small counter helper.
package frequency_analysis_sequencer_pkg;

   typedef logic [1:0] reg_op_t;

   localparam reg_op_t REGISTER_NOP_OPERATION   = 2'd0;
   localparam reg_op_t REGISTER_WRITE_OPERATION = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CLEAR    = 3'd1,
      ST_MEASURE  = 3'd2,
      ST_SNAPSHOT = 3'd3,
      ST_WRITE    = 3'd4,
      ST_DONE     = 3'd5
   } state_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] value);
      return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/frequency_analysis_sequencer_if.sv
// Analyzer control and register-write bus between the sequencer (master)
// and the analyzer bank / axi_slave_impl register port (slave).
//
// Handshake: the register port has no back-pressure. Every cycle in which
// register_operation equals REGISTER_WRITE_OPERATION carries exactly one
// write of register_write into register_number; the slave must accept it
// in that cycle. REGISTER_NOP_OPERATION cycles carry no transfer.
interface frequency_analysis_sequencer_if
   import frequency_analysis_sequencer_pkg::*;
#(
   parameter int NUM_CHANNELS = 6
) ();

   logic                        analyzer_enable;
   logic                        analyzer_clear_n;
   logic [32*NUM_CHANNELS-1:0]  f_values;
   reg_op_t                     register_operation;
   logic [7:0]                  register_number;
   logic [31:0]                 register_write;

   modport master (
      output analyzer_enable,
      output analyzer_clear_n,
      input  f_values,
      output register_operation,
      output register_number,
      output register_write
   );

   modport slave (
      input  analyzer_enable,
      input  analyzer_clear_n,
      output f_values,
      input  register_operation,
      input  register_number,
      input  register_write
   );

endinterface

// File: rtl/frequency_analysis_sequencer_async_edge_detector.sv
// Two-flop synchronizer followed by an edge register. A rising edge of the
// asynchronous level sampled at clock k gives a one-cycle pulse at k+2.
module async_edge_detector (
   input  logic clk,
   input  logic rst_n,
   input  logic level,
   output logic pulse
);

   logic sync_a;
   logic sync_b;
   logic prev;

   // Synchronize the level, remember the previous value and register the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
         prev   <= 1'b0;
         pulse  <= 1'b0;
      end else begin
         sync_a <= level;
         sync_b <= sync_a;
         prev   <= sync_b;
         pulse  <= sync_b & ~prev;
      end
   end

endmodule

// File: rtl/frequency_analysis_sequencer.sv
// One measurement run of the pixel frequency analyzers: clear, enable
// window, snapshot of the results, register write-back, then interrupt.
// All outputs are registered from the next state, so every output changes
// on the same edge as the state it belongs to.
module frequency_analysis_sequencer
   import frequency_analysis_sequencer_pkg::*;
#(
   parameter int NUM_CHANNELS       = 6,
   parameter int CLEAR_CYCLES       = 4,
   parameter int MAX_MEASURE_CYCLES = 100000000,
   parameter int FIRST_REGISTER     = 1
) (
   input  logic                                 s00_axi_aclk,
   input  logic                                 s00_axi_aresetn,
   input  logic                                 start,
   input  logic                                 stop,
   frequency_analysis_sequencer_if.master       bus,
   output logic                                 busy,
   output logic                                 timeout,
   output logic [31:0]                          measure_cycles,
   output logic                                 irq,
   output state_t                               fsm_state
);

   localparam logic [15:0] CLEAR_LAST = 16'(CLEAR_CYCLES - 1);
   localparam logic [7:0]  WRITE_LAST = 8'(NUM_CHANNELS - 1);
   localparam bit          LIMIT_ON   = (MAX_MEASURE_CYCLES != 0);
   localparam logic [31:0] LIMIT_LAST = LIMIT_ON ? 32'(MAX_MEASURE_CYCLES - 1) : 32'hFFFF_FFFF;

   state_t        state;
   state_t        next_state;
   logic          start_evt;
   logic          stop_evt;
   logic          stop_pend;
   logic          hit_limit;
   logic [15:0]   clear_cnt;
   logic [31:0]   cycle_cnt;
   logic [7:0]    write_idx;
   logic [7:0]    next_idx;
   logic [31:0]   live [NUM_CHANNELS];
   logic [31:0]   snap_buf [NUM_CHANNELS];
   reg_op_t       op_next;
   logic [7:0]    num_next;
   logic [31:0]   data_next;

   async_edge_detector u_start_edge (
      .clk   (s00_axi_aclk),
      .rst_n (s00_axi_aresetn),
      .level (start),
      .pulse (start_evt)
   );

   async_edge_detector u_stop_edge (
      .clk   (s00_axi_aclk),
      .rst_n (s00_axi_aresetn),
      .level (stop),
      .pulse (stop_evt)
   );

   for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_unpack
      assign live[g] = bus.f_values[32*g +: 32];
   end

   assign hit_limit = LIMIT_ON && (cycle_cnt == LIMIT_LAST);
   assign fsm_state = state;

   // State register.
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) state <= ST_IDLE;
      else                  state <= next_state;
   end

   // Next state plus the write-port values for the cycle after this edge.
   always_comb begin
      next_state = state;
      next_idx   = 8'd0;
      op_next    = REGISTER_NOP_OPERATION;
      num_next   = 8'd0;
      data_next  = 32'd0;
      case (state)
         ST_IDLE:     if (start_evt) next_state = ST_CLEAR;
         ST_CLEAR:    if (clear_cnt == CLEAR_LAST) next_state = ST_MEASURE;
         ST_MEASURE:  if (stop_evt || stop_pend || hit_limit) next_state = ST_SNAPSHOT;
         ST_SNAPSHOT: next_state = ST_WRITE;
         ST_WRITE:    if (write_idx == WRITE_LAST) next_state = ST_DONE;
         ST_DONE:     if (start_evt) next_state = ST_CLEAR;
         default:     next_state = ST_IDLE;
      endcase
      if (next_state == ST_WRITE) begin
         // Channel 0 leaves on the edge that also loads the snapshot, so it
         // is taken straight from the live results; later channels come
         // from the snapshot buffer.
         next_idx = (state == ST_WRITE) ? write_idx + 8'd1 : 8'd0;
         op_next  = REGISTER_WRITE_OPERATION;
         num_next = 8'(FIRST_REGISTER) + next_idx;
         if (state == ST_SNAPSHOT) begin
            data_next = live[0];
         end else begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
               if (next_idx == 8'(i)) data_next = snap_buf[i];
            end
         end
      end
   end

   // Clear-phase, measurement and write-index counters plus the pending stop.
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         clear_cnt <= 16'd0;
         cycle_cnt <= 32'd0;
         write_idx <= 8'd0;
         stop_pend <= 1'b0;
      end else begin
         clear_cnt <= (state == ST_CLEAR) ? clear_cnt + 16'd1 : 16'd0;
         write_idx <= (state == ST_WRITE) ? write_idx + 8'd1 : 8'd0;
         if (state == ST_CLEAR)        cycle_cnt <= 32'd0;
         else if (state == ST_MEASURE) cycle_cnt <= sat_inc(cycle_cnt);
         // A stop seen while clearing ends the window after its first cycle.
         if (state == ST_CLEAR)        stop_pend <= stop_pend | stop_evt;
         else if (state != ST_MEASURE) stop_pend <= 1'b0;
      end
   end

   // Result snapshot, window length and the sticky timeout flag.
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         for (int i = 0; i < NUM_CHANNELS; i++) snap_buf[i] <= 32'd0;
         measure_cycles <= 32'd0;
         timeout        <= 1'b0;
      end else begin
         if (state == ST_SNAPSHOT) begin
            snap_buf       <= live;
            measure_cycles <= cycle_cnt;
         end
         if (next_state == ST_CLEAR && state != ST_CLEAR) begin
            timeout <= 1'b0;
         end else if (state == ST_MEASURE && hit_limit && !stop_evt && !stop_pend) begin
            timeout <= 1'b1;
         end
      end
   end

   // Registered outputs, decoded from the state being entered.
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         bus.analyzer_enable    <= 1'b0;
         bus.analyzer_clear_n   <= 1'b1;
         bus.register_operation <= REGISTER_NOP_OPERATION;
         bus.register_number    <= 8'd0;
         bus.register_write     <= 32'd0;
         busy                   <= 1'b0;
         irq                    <= 1'b0;
      end else begin
         bus.analyzer_enable    <= (next_state == ST_MEASURE);
         bus.analyzer_clear_n   <= (next_state != ST_CLEAR);
         bus.register_operation <= op_next;
         bus.register_number    <= num_next;
         bus.register_write     <= data_next;
         busy                   <= (next_state != ST_IDLE) && (next_state != ST_DONE);
         irq                    <= (next_state == ST_DONE);
      end
   end

endmodule

// File: tb/tb_frequency_analysis_sequencer.sv
// Directed-sequence bench for the frequency analysis sequencer with
// randomized result words and window lengths.
module tb_frequency_analysis_sequencer;
   import frequency_analysis_sequencer_pkg::*;

   localparam int NUM   = 6;
   localparam int CLRC  = 4;
   localparam int MAXC  = 1200;
   localparam int FIRST = 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        busy;
   logic        timeout;
   logic [31:0] measure_cycles;
   logic        irq;
   state_t      fsm_state;

   frequency_analysis_sequencer_if #(.NUM_CHANNELS(NUM)) bus ();

   frequency_analysis_sequencer #(
      .NUM_CHANNELS       (NUM),
      .CLEAR_CYCLES       (CLRC),
      .MAX_MEASURE_CYCLES (MAXC),
      .FIRST_REGISTER     (FIRST)
   ) dut (
      .s00_axi_aclk    (clk),
      .s00_axi_aresetn (rst_n),
      .start           (start),
      .stop            (stop),
      .bus             (bus),
      .busy            (busy),
      .timeout         (timeout),
      .measure_cycles  (measure_cycles),
      .irq             (irq),
      .fsm_state       (fsm_state)
   );

   // Clock.
   always #5 clk = ~clk;

   int          n_pass = 0;
   int          n_total = 0;
   int          cyc = 0;
   int          en_cnt = 0;
   logic [41:0] exp_q [$];
   logic [41:0] obs_q [$];
   int          obs_cyc [$];
   logic [31:0] vals [NUM];

   always @(posedge clk) cyc++;

   // Observe enable-window length and every write on the register port.
   always @(negedge clk) begin
      if (bus.analyzer_enable === 1'b1) en_cnt++;
      if (bus.register_operation !== 2'd0) begin
         obs_q.push_back({bus.register_operation, bus.register_number, bus.register_write});
         obs_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic set_vals(input bit random);
      for (int i = 0; i < NUM; i++) vals[i] = random ? $urandom : 32'(200 + i);
      bus.f_values = {vals[5], vals[4], vals[3], vals[2], vals[1], vals[0]};
   endtask

   // Model: one write per channel, ascending register numbers, snapshot data.
   task automatic build_expected();
      exp_q.delete();
      for (int i = 0; i < NUM; i++) exp_q.push_back({2'd2, 8'(FIRST + i), vals[i]});
   endtask

   // Rising start edge sampled at edge k: CLEAR from k+3, enable from k+7.
   task automatic start_run(input string tag, input bit from_done, input bit stop_in_clear);
      en_cnt = 0;
      obs_q.delete();
      obs_cyc.delete();
      start = 1'b1;
      @(negedge clk);
      if (stop_in_clear) stop = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      check({tag, "_busy_pre"}, busy, 0);
      check({tag, "_irq_pre"}, irq, from_done);
      @(negedge clk);
      check({tag, "_busy_clear"}, busy, 1);
      check({tag, "_clear_n_low"}, bus.analyzer_clear_n, 0);
      check({tag, "_irq_clear"}, irq, 0);
      check({tag, "_timeout_cleared"}, timeout, 0);
      if (!stop_in_clear) begin
         int cl = 1;
         int en_at = -1;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.analyzer_clear_n === 1'b0) cl++;
            if (bus.analyzer_enable === 1'b1) begin
               en_at = i;
               break;
            end
         end
         check({tag, "_clear_len"}, 64'(cl), 64'(CLRC));
         check({tag, "_enable_at"}, 64'(en_at), 64'(CLRC - 1));
      end
   endtask

   // Stop rises after w more cycles; the window is then w+4 cycles long
   // when counted from the first enabled cycle.
   task automatic do_stop(input int w);
      repeat (w) @(negedge clk);
      stop = 1'b1;
      repeat (2) @(negedge clk);
      stop = 1'b0;
   endtask

   task automatic finish_run(input string tag, input int bound, input int exp_window, input bit exp_timeout);
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (irq === 1'b1) break;
      end
      check({tag, "_irq_done"}, irq, 1);
      check({tag, "_busy_done"}, busy, 0);
      check({tag, "_op_idle"}, bus.register_operation, 0);
      check({tag, "_num_idle"}, bus.register_number, 0);
      check({tag, "_window"}, 64'(en_cnt), 64'(exp_window));
      check({tag, "_measure_cycles"}, measure_cycles, 64'(exp_window));
      check({tag, "_timeout"}, timeout, exp_timeout);
      check({tag, "_wr_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         check($sformatf("%s_wr%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
      if (obs_cyc.size() == NUM)
         check({tag, "_wr_consecutive"}, 64'(obs_cyc[NUM-1] - obs_cyc[0]), 64'(NUM - 1));
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_state"}, fsm_state, ST_IDLE);
      check({tag, "_enable"}, bus.analyzer_enable, 0);
      check({tag, "_clear_n"}, bus.analyzer_clear_n, 1);
      check({tag, "_op"}, bus.register_operation, 0);
      check({tag, "_num"}, bus.register_number, 0);
      check({tag, "_data"}, bus.register_write, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_timeout"}, timeout, 0);
      check({tag, "_measure"}, measure_cycles, 0);
      check({tag, "_irq"}, irq, 0);
   endtask

   initial begin
      int w1;
      int w2;
      bit seen;
      bus.f_values = '0;

      // Reset.
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Run A: stop 1000 cycles into the window, results 200..205.
      set_vals(1'b0);
      build_expected();
      start_run("runA", 1'b0, 1'b0);
      do_stop(996);
      finish_run("runA", 40, 1000, 1'b0);
      repeat (3) @(negedge clk);

      // Run B: start during MEASURE is ignored; results change during WRITE.
      set_vals(1'b1);
      build_expected();
      start_run("runB", 1'b1, 1'b0);
      w1 = $urandom_range(5, 50);
      w2 = $urandom_range(20, 300);
      repeat (w1) @(negedge clk);
      start = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      do_stop(w2);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.register_operation === 2'd2) begin
            seen = 1'b1;
            break;
         end
      end
      check("runB_write_seen", seen, 1);
      bus.f_values = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      finish_run("runB", 40, w1 + 2 + w2 + 4, 1'b0);
      repeat (2) @(negedge clk);

      // Run C: no stop, the window ends on the cycle limit.
      set_vals(1'b1);
      build_expected();
      start_run("runC", 1'b1, 1'b0);
      finish_run("runC", MAXC + 100, MAXC, 1'b1);
      repeat (2) @(negedge clk);

      // Run D: stop edge during CLEAR gives a one-cycle window.
      set_vals(1'b1);
      build_expected();
      start_run("runD", 1'b1, 1'b1);
      finish_run("runD", 40, 1, 1'b0);
      repeat (2) @(negedge clk);

      // Run E: reset on the third write cycle aborts the write-back.
      set_vals(1'b1);
      build_expected();
      start_run("runE", 1'b1, 1'b0);
      do_stop(20);
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.register_operation === 2'd2 && bus.register_number === 8'(FIRST + 2)) begin
            seen = 1'b1;
            break;
         end
      end
      check("runE_third_write_seen", seen, 1);
      rst_n = 1'b0;
      #1;
      check_reset_values("midrun_reset");
      check("runE_writes_before_reset", 64'(obs_q.size()), 64'd3);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("runE_no_writes_after", 64'(obs_q.size()), 64'd3);
      check("runE_busy_after", busy, 0);
      check("runE_irq_after", irq, 0);
      check("runE_state_after", fsm_state, ST_IDLE);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
